control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Fetch/decode/execute FSM that sequences the 16-bit microcontroller datapath.
//  Fetches an instruction over the memory handshake and loads the IR.
//  Drives one-cycle class strobes (ALU, MOV, LOAD/STORE) to the datapath, then
//  runs the memory-access and register-writeback phases. Sits between program
//  memory, the IR, the register file and the execution units.
// PARAMETERS
//  IW      16  instruction width; opcode is instr[IW-1:IW-4]
//  CNTW    16  width of retired-instruction counter icount
// PORTS
//  clk       in   1     system clock, all state changes on posedge
//  reset     in   1     synchronous reset, active-low (0 = reset at posedge clk)
//  run       in   1     1 = keep executing; sampled only at instruction boundaries
//  instr     in   IW    memory read data, valid when mem_ack=1
//  mem_ack   in   1     memory handshake acknowledge, single cycle
//  mem_req   out  1     memory request, held until mem_ack
//  mem_we    out  1     1 = write (STORE), 0 = read
//  ir_load   out  1     load IR from instr this cycle
//  pc_inc    out  1     increment PC this cycle
//  alu_str   out  1     ALU-class strobe (opcodes 0-8)
//  mov_str   out  1     MOV/MOVI strobe (opcodes 9-10)
//  ldsr_str  out  1     LOAD/STORE strobe (opcodes 11-12)
//  reg_we    out  1     register-file write enable
//  illegal   out  1     sticky illegal-opcode flag (0 unless ILLEGAL_TRAP_EN)
//  state     out  3     current FSM state encoding, for debug
//  icount    out  CNTW  retired-instruction counter
// BEHAVIOUR
//  - States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; 7 is
//    unreachable and decodes as IDLE.
//  - Reset (reset=0 at posedge): state<=IDLE, internal IR<=0, icount<=0,
//    illegal<=0. Reset has priority over every other event, including mid-FETCH
//    or mid-MEM; an outstanding request is abandoned. All outputs are decoded
//    from the registered state and IR opcode, so every output is 0 in IDLE.
//  - IDLE: all strobes 0. If run=1, next state is FETCH.
//  - FETCH: mem_req=1, mem_we=0. Waits any number of cycles for mem_ack.
//    In the mem_ack=1 cycle: ir_load=1 and pc_inc=1 (combinational with ack).
//    The internal IR captures instr at that edge; next state is DECODE.
//  - DECODE: one cycle; exactly one strobe is high, selected by the IR opcode:
//    0-8  -> alu_str=1, next EXEC
//    9-10 -> mov_str=1, next EXEC
//    11   -> ldsr_str=1, next MEM (read)
//    12   -> ldsr_str=1, next MEM (write)
//    13-15 -> no strobe; next TRAP if ILLEGAL_TRAP_EN, else retire as NOP
//  - EXEC: one cycle with no strobes; next WB.
//  - MEM: mem_req=1; mem_we=1 only for STORE. Waits for mem_ack.
//    On ack, LOAD goes to WB; STORE retires.
//  - WB: reg_we=1 for one cycle, then the instruction retires.
//  - Retire (at the exiting edge of WB, MEM-STORE, or DECODE-NOP):
//    icount<=icount+1, wrapping modulo 2^CNTW (0xFFFF -> 0x0000).
//    Next state is FETCH if run=1, else IDLE.
//  - run is sampled only at IDLE and at retire. Deasserting run mid-instruction
//    lets the instruction complete, then the FSM goes to IDLE.
//  - mem_ack outside FETCH or MEM is ignored. mem_req never drops before ack
//    except on reset.
//  - Latency with zero-wait memory (ack in the first request cycle), in cycles
//    from entering FETCH to retire: ALU/MOV=4, LOAD=4, STORE=3, NOP=2.
//  - Strobes are mutually exclusive; no two of alu_str, mov_str, ldsr_str and
//    reg_we are high in the same cycle.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: opcode 13-15 in DECODE -> TRAP. In TRAP, illegal=1
//    and all other strobes are 0; the state holds until reset=0. No retire,
//    icount unchanged.
//  ILLEGAL_TRAP_EN undefined: opcodes 13-15 retire as NOP. illegal is tied 0
//    and TRAP is unreachable.
// TESTING
//  1 reset=0 for 2 cycles during FETCH with mem_req=1 -> state=0, every output 0,
//    icount=0 on the next cycle.
//  2 run=1, ack immediate, instr=16'h1234 (ADDI) -> ir_load/pc_inc in the FETCH
//    cycle, alu_str one cycle later, reg_we two cycles after that, icount=1
//    after 4 cycles.
//  3 instr=16'hB000 (LOAD), ack delayed 3 cycles in MEM -> mem_req held with
//    mem_we=0 for 3 cycles, then WB with reg_we=1; instr=16'hC000 (STORE) ->
//    mem_we=1 in MEM and no reg_we.
//  4 run dropped in the DECODE cycle of a MOV (16'hA000) -> EXEC and WB still
//    execute, icount increments, then state=IDLE with no new mem_req.
//  5 instr=16'hF000: without the macro -> no strobe, icount+1, next FETCH;
//    with ILLEGAL_TRAP_EN -> state=6, illegal=1, held until reset.
//  6 preload icount=0xFFFF by running 65535 NOPs, retire one more ->
//    icount=0x0000.

Source files
------------

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the 16-bit microcontroller datapath.
// Optional build macro ILLEGAL_TRAP_EN: opcodes 13-15 trap instead of retiring as NOP.
module control_sequencer #(
  parameter int IW   = 16,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [IW-1:0]   instr,
  input  logic            mem_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic            ir_load,
  output logic            pc_inc,
  output logic            alu_str,
  output logic            mov_str,
  output logic            ldsr_str,
  output logic            reg_we,
  output logic            illegal,
  output logic [2:0]      state,
  output logic [CNTW-1:0] icount
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t          state_reg;
  logic [3:0]      op_reg;
  logic [CNTW-1:0] icount_reg;

  // Only the opcode field steers sequencing; operand bits belong to the datapath IR.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[IW-5:0];

  logic op_alu, op_mov, op_load, op_store, op_bad;
  assign op_alu   = (op_reg <= 4'd8);
  assign op_mov   = (op_reg == 4'd9) || (op_reg == 4'd10);
  assign op_load  = (op_reg == 4'd11);
  assign op_store = (op_reg == 4'd12);
  assign op_bad   = (op_reg >= 4'd13);

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
  logic illegal_reg;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic retire;
  assign retire = (state_reg == S_WB)
               || ((state_reg == S_MEM) && mem_ack && op_store)
               || ((state_reg == S_DECODE) && op_bad && !TRAP_EN);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      op_reg     <= 4'd0;
      icount_reg <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (mem_ack) begin
            op_reg    <= instr[IW-1:IW-4];
            state_reg <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (op_alu || op_mov) begin
            state_reg <= S_EXEC;
          end else if (op_load || op_store) begin
            state_reg <= S_MEM;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            state_reg   <= S_TRAP;
            illegal_reg <= 1'b1;
`endif
          end
        end
        S_EXEC: state_reg <= S_WB;
        S_MEM: begin
          if (mem_ack && op_load) state_reg <= S_WB;
        end
`ifdef ILLEGAL_TRAP_EN
        S_TRAP: state_reg <= S_TRAP;
`endif
        default: begin
          // IDLE, and the unreachable encodings, restart only when run is set.
          state_reg <= run ? S_FETCH : S_IDLE;
        end
      endcase

      // Retire overrides the per-state next state: count it and resample run.
      if (retire) begin
        icount_reg <= icount_reg + CNTW'(1);
        state_reg  <= run ? S_FETCH : S_IDLE;
      end
    end
  end

  assign mem_req  = (state_reg == S_FETCH) || (state_reg == S_MEM);
  assign mem_we   = (state_reg == S_MEM) && op_store;
  assign ir_load  = (state_reg == S_FETCH) && mem_ack;
  assign pc_inc   = (state_reg == S_FETCH) && mem_ack;
  assign alu_str  = (state_reg == S_DECODE) && op_alu;
  assign mov_str  = (state_reg == S_DECODE) && op_mov;
  assign ldsr_str = (state_reg == S_DECODE) && (op_load || op_store);
  assign reg_we   = (state_reg == S_WB);
  assign state    = state_reg;
  assign icount   = icount_reg;

`ifdef ILLEGAL_TRAP_EN
  assign illegal = illegal_reg;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: reset, instruction classes, run drop,
// illegal opcodes and counter wrap (on a narrow-counter second instance).
module tb_control_sequencer;

  localparam logic [8:0] V_REQ  = 9'h100;
  localparam logic [8:0] V_WE   = 9'h080;
  localparam logic [8:0] V_IRL  = 9'h040;
  localparam logic [8:0] V_PCI  = 9'h020;
  localparam logic [8:0] V_ALU  = 9'h010;
  localparam logic [8:0] V_MOV  = 9'h008;
  localparam logic [8:0] V_LDSR = 9'h004;
  localparam logic [8:0] V_RWE  = 9'h002;
  localparam logic [8:0] V_ILL  = 9'h001;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, ir_load, pc_inc, alu_str, mov_str, ldsr_str, reg_we, illegal;
  logic [2:0]  state;
  logic [15:0] icount;

  logic        run_w = 1'b0;
  logic [15:0] instr_w = 16'h0000;
  logic        mem_ack_w = 1'b0;
  logic        mem_req_w, mem_we_w, ir_load_w, pc_inc_w, alu_str_w, mov_str_w, ldsr_str_w;
  logic        reg_we_w, illegal_w;
  logic [2:0]  state_w;
  logic [3:0]  icount_w;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  control_sequencer #(.IW(16), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load), .pc_inc(pc_inc),
    .alu_str(alu_str), .mov_str(mov_str), .ldsr_str(ldsr_str), .reg_we(reg_we),
    .illegal(illegal), .state(state), .icount(icount)
  );

  control_sequencer #(.IW(16), .CNTW(4)) dut_w (
    .clk(clk), .reset(reset), .run(run_w), .instr(instr_w), .mem_ack(mem_ack_w),
    .mem_req(mem_req_w), .mem_we(mem_we_w), .ir_load(ir_load_w), .pc_inc(pc_inc_w),
    .alu_str(alu_str_w), .mov_str(mov_str_w), .ldsr_str(ldsr_str_w), .reg_we(reg_we_w),
    .illegal(illegal_w), .state(state_w), .icount(icount_w)
  );

  logic [8:0] vec;
  assign vec = {mem_req, mem_we, ir_load, pc_inc, alu_str, mov_str, ldsr_str, reg_we, illegal};

  // Advance past the next active edge; outputs are then stable for sampling.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; run = 1'b0; mem_ack = 1'b0;
    step(2);
    reset = 1'b1; run = 1'b1;
    step(1);
    checks++; if (state !== 3'd1) begin fails++; $display("FAIL reset_enter_fetch state got %0d want 1", state); end
    checks++; if (vec !== V_REQ) begin fails++; $display("FAIL reset_fetch_out got %03h want %03h", vec, V_REQ); end
    step(1);
    reset = 1'b0;
    step(2);
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (vec !== 9'h000) begin fails++; $display("FAIL reset_outputs got %03h want 000", vec); end
    checks++; if (icount !== 16'h0000) begin fails++; $display("FAIL reset_icount got %04h want 0000", icount); end
    run = 1'b0; reset = 1'b1;
    step(1);
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL idle_hold state got %0d want 0", state); end
    $display("txn reset: state=%0d outputs=%03h icount=%04h", state, vec, icount);
  endtask

  task automatic test_alu;
    run = 1'b1;
    step(1);
    mem_ack = 1'b1; instr = 16'h1234;
    #1;
    checks++; if (vec !== (V_REQ | V_IRL | V_PCI)) begin fails++; $display("FAIL alu_fetch_out got %03h want %03h", vec, V_REQ | V_IRL | V_PCI); end
    step(1);
    mem_ack = 1'b0;
    #1;
    checks++; if (state !== 3'd2 || vec !== V_ALU) begin fails++; $display("FAIL alu_decode got state %0d out %03h want state 2 out %03h", state, vec, V_ALU); end
    step(1);
    checks++; if (state !== 3'd3 || vec !== 9'h000) begin fails++; $display("FAIL alu_exec got state %0d out %03h want state 3 out 000", state, vec); end
    step(1);
    checks++; if (state !== 3'd5 || vec !== V_RWE || icount !== 16'd0) begin fails++; $display("FAIL alu_wb got state %0d out %03h icount %0d want state 5 out %03h icount 0", state, vec, icount, V_RWE); end
    step(1);
    checks++; if (state !== 3'd1 || icount !== 16'd1) begin fails++; $display("FAIL alu_retire got state %0d icount %0d want state 1 icount 1", state, icount); end
    $display("txn ADDI 1234: retired icount=%0d", icount);
  endtask

  task automatic test_load_store;
    mem_ack = 1'b1; instr = 16'hB000;
    step(1);
    mem_ack = 1'b0;
    #1;
    checks++; if (vec !== V_LDSR) begin fails++; $display("FAIL load_decode got %03h want %03h", vec, V_LDSR); end
    step(1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (state !== 3'd4 || vec !== V_REQ) begin fails++; $display("FAIL load_mem_wait%0d got state %0d out %03h want state 4 out %03h", i, state, vec, V_REQ); end
      step(1);
    end
    mem_ack = 1'b1;
    #1;
    checks++; if (vec !== V_REQ) begin fails++; $display("FAIL load_mem_ack got %03h want %03h", vec, V_REQ); end
    step(1);
    mem_ack = 1'b0;
    #1;
    checks++; if (state !== 3'd5 || vec !== V_RWE) begin fails++; $display("FAIL load_wb got state %0d out %03h want state 5 out %03h", state, vec, V_RWE); end
    step(1);
    checks++; if (state !== 3'd1 || icount !== 16'd2) begin fails++; $display("FAIL load_retire got state %0d icount %0d want state 1 icount 2", state, icount); end
    $display("txn LOAD B000 (3 wait): retired icount=%0d", icount);

    mem_ack = 1'b1; instr = 16'hC000;
    step(1);
    mem_ack = 1'b0;
    #1;
    checks++; if (vec !== V_LDSR) begin fails++; $display("FAIL store_decode got %03h want %03h", vec, V_LDSR); end
    step(1);
    checks++; if (state !== 3'd4 || vec !== (V_REQ | V_WE)) begin fails++; $display("FAIL store_mem got state %0d out %03h want state 4 out %03h", state, vec, V_REQ | V_WE); end
    mem_ack = 1'b1;
    step(1);
    mem_ack = 1'b0;
    #1;
    checks++; if (state !== 3'd1 || icount !== 16'd3 || reg_we !== 1'b0) begin fails++; $display("FAIL store_retire got state %0d icount %0d reg_we %0b want state 1 icount 3 reg_we 0", state, icount, reg_we); end
    $display("txn STORE C000: retired icount=%0d", icount);
  endtask

  task automatic test_run_drop;
    mem_ack = 1'b1; instr = 16'hA000;
    step(1);
    run = 1'b0;
    #1;
    checks++; if (state !== 3'd2 || vec !== V_MOV) begin fails++; $display("FAIL mov_decode got state %0d out %03h want state 2 out %03h", state, vec, V_MOV); end
    step(1);
    checks++; if (state !== 3'd3 || vec !== 9'h000) begin fails++; $display("FAIL mov_exec_ack_ignored got state %0d out %03h want state 3 out 000", state, vec); end
    step(1);
    checks++; if (state !== 3'd5 || vec !== V_RWE) begin fails++; $display("FAIL mov_wb got state %0d out %03h want state 5 out %03h", state, vec, V_RWE); end
    mem_ack = 1'b0;
    step(1);
    checks++; if (state !== 3'd0 || icount !== 16'd4 || vec !== 9'h000) begin fails++; $display("FAIL mov_to_idle got state %0d icount %0d out %03h want state 0 icount 4 out 000", state, icount, vec); end
    step(1);
    checks++; if (state !== 3'd0 || mem_req !== 1'b0) begin fails++; $display("FAIL mov_idle_hold got state %0d mem_req %0b want state 0 mem_req 0", state, mem_req); end
    $display("txn MOV A000 with run drop: icount=%0d state=%0d", icount, state);
  endtask

  task automatic test_illegal;
    run = 1'b1;
    step(1);
    mem_ack = 1'b1; instr = 16'hF000;
    step(1);
    mem_ack = 1'b0;
    #1;
    checks++; if (state !== 3'd2 || vec !== 9'h000) begin fails++; $display("FAIL illegal_decode got state %0d out %03h want state 2 out 000", state, vec); end
    step(1);
`ifdef ILLEGAL_TRAP_EN
    checks++; if (state !== 3'd6 || vec !== V_ILL || icount !== 16'd4) begin fails++; $display("FAIL trap_enter got state %0d out %03h icount %0d want state 6 out %03h icount 4", state, vec, icount, V_ILL); end
    step(3);
    checks++; if (state !== 3'd6 || illegal !== 1'b1 || icount !== 16'd4) begin fails++; $display("FAIL trap_hold got state %0d illegal %0b icount %0d want state 6 illegal 1 icount 4", state, illegal, icount); end
`else
    checks++; if (state !== 3'd1 || vec !== V_REQ || icount !== 16'd5) begin fails++; $display("FAIL nop_retire got state %0d out %03h icount %0d want state 1 out %03h icount 5", state, vec, icount, V_REQ); end
`endif
    $display("txn F000: state=%0d illegal=%0b icount=%0d", state, illegal, icount);
    run = 1'b0; reset = 1'b0;
    step(1);
    reset = 1'b1;
    #1;
    checks++; if (state !== 3'd0 || illegal !== 1'b0 || icount !== 16'd0) begin fails++; $display("FAIL illegal_reset got state %0d illegal %0b icount %0d want 0 0 0", state, illegal, icount); end
  endtask

  task automatic test_back_to_back;
    run = 1'b1; mem_ack = 1'b1; instr = 16'h1234;
    step(1);
    step(4);
    checks++; if (state !== 3'd1 || icount !== 16'd1) begin fails++; $display("FAIL b2b_first got state %0d icount %0d want state 1 icount 1", state, icount); end
    step(8);
    checks++; if (state !== 3'd1 || icount !== 16'd3) begin fails++; $display("FAIL b2b_third got state %0d icount %0d want state 1 icount 3", state, icount); end
    run = 1'b0; mem_ack = 1'b0;
    $display("txn 3x ADDI back-to-back: icount=%0d", icount);
  endtask

  task automatic test_wrap;
    run_w = 1'b1; mem_ack_w = 1'b1; instr_w = 16'hC000;
    step(1);
    step(45);
    checks++; if (state_w !== 3'd1 || icount_w !== 4'hF) begin fails++; $display("FAIL wrap_preload got state %0d icount %0h want state 1 icount f", state_w, icount_w); end
    step(3);
    checks++; if (state_w !== 3'd1 || icount_w !== 4'h0) begin fails++; $display("FAIL wrap_rollover got state %0d icount %0h want state 1 icount 0", state_w, icount_w); end
    run_w = 1'b0; mem_ack_w = 1'b0;
    $display("txn 16 STOREs on 4-bit counter: icount=%0h", icount_w);
  endtask

  initial begin
    test_reset;
    test_alu;
    test_load_store;
    test_run_drop;
    test_illegal;
    test_back_to_back;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
